// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - 640x480@60 default geometry (pixel clock ~25.175 MHz)
//   - sync polarity enum
//   - vga_total(): sums the four segments of a line or frame
package vga_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    localparam int unsigned VGA_H_ACTIVE    = 640;
    localparam int unsigned VGA_H_FP        = 16;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BP        = 48;
    localparam int unsigned VGA_V_ACTIVE    = 480;
    localparam int unsigned VGA_V_FP        = 10;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BP        = 33;
    localparam sync_pol_e   VGA_HSYNC_POL   = SYNC_ACTIVE_LOW;
    localparam sync_pol_e   VGA_VSYNC_POL   = SYNC_ACTIVE_LOW;
    localparam int unsigned VGA_PIX_LATENCY = 1;
    localparam int unsigned VGA_CW          = 10;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register of W-bit words.
//   clk    in  1  clock
//   rst_n  in  1  asynchronous reset, active-low; all stages go to RST_VAL
//   clr    in  1  synchronous clear; all stages load RST_VAL
//   d      in  W  input word
//   q      out W  d delayed by DEPTH clocks (DEPTH=0: combinational pass-through)
module vga_delay_line #(
    parameter int unsigned    W       = 3,
    parameter int unsigned    DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, clr};
        assign q = d;
    end else begin : g_chain
        logic [DEPTH-1:0][W-1:0] stg_q, stg_d;
        logic [DEPTH:0][W-1:0]   chain;   // chain[0]=d, chain[i+1]=stage i

        always_comb begin
            chain = {stg_q, d};
            stg_d = stg_q;
            for (int i = 0; i < int'(DEPTH); i++) begin
                stg_d[i] = clr ? RST_VAL : chain[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stg_q <= {DEPTH{RST_VAL}};
            else        stg_q <= stg_d;
        end

        assign q = stg_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
//   pixel_clk   in   1   pixel clock
//   reset_n     in   1   asynchronous reset, active-low
//   en          in   1   run enable; low parks the raster at (0,0) and clears frame_count
//   x_coord     out  CW  current column (undelayed)
//   y_coord     out  CW  current line (undelayed)
//   active      out  1   inside visible area (undelayed), pixel-generator enable
//   hsync/vsync out  1   sync pulses, delayed PIX_LATENCY to match registered RGB
//   de          out  1   data enable, delayed PIX_LATENCY
//   line_start  out  1   x_coord==0 while enabled
//   frame_start out  1   x_coord==0 && y_coord==0 while enabled
//   frame_count out  8   frames completed since reset/restart, wraps
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter sync_pol_e   HSYNC_POL   = VGA_HSYNC_POL,
    parameter sync_pol_e   VSYNC_POL   = VGA_VSYNC_POL,
    parameter int unsigned PIX_LATENCY = VGA_PIX_LATENCY,
    parameter int unsigned CW          = VGA_CW
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          en,
    output logic [CW-1:0] x_coord,
    output logic [CW-1:0] y_coord,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic HS_ON = HSYNC_POL;
    localparam logic VS_ON = VSYNC_POL;
    // Idle word for the {hsync, vsync, de} delay line.
    localparam logic [2:0] IDLE = {~HS_ON, ~VS_ON, 1'b0};

    if ((H_TOTAL > (32'd1 << CW)) || (V_TOTAL > (32'd1 << CW)) || (PIX_LATENCY > 7))
    begin : g_bad_params
        $error("vga_timing_gen: CW=%0d cannot hold totals, or PIX_LATENCY > 7", CW);
    end

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]    fc_q, fc_d;
    logic [31:0]   x_w, y_w;
    logic          hs_raw, vs_raw;
    logic [2:0]    dly_q;

    // Raster advance; disabling parks at (0,0) so re-enable starts a clean frame.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (!en) begin
            x_d  = '0;
            y_d  = '0;
            fc_d = '0;
        end else if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
                y_d  = '0;
                fc_d = fc_q + 8'd1;
            end else begin
                y_d = y_q + CW'(1);
            end
        end else begin
            x_d = x_q + CW'(1);
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q  <= '0;
            y_q  <= '0;
            fc_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    // Widen once so every compare is against a 32-bit geometry constant.
    assign x_w = 32'(x_q);
    assign y_w = 32'(y_q);

    assign active = (x_w < H_ACTIVE) && (y_w < V_ACTIVE) && en;
    assign hs_raw = ((x_w >= HS_BEG) && (x_w < HS_END)) ? HS_ON : ~HS_ON;
    assign vs_raw = ((y_w >= VS_BEG) && (y_w < VS_END)) ? VS_ON : ~VS_ON;

    vga_delay_line #(
        .W       (3),
        .DEPTH   (PIX_LATENCY),
        .RST_VAL (IDLE)
    ) u_dly (
        .clk   (pixel_clk),
        .rst_n (reset_n),
        .clr   (~en),
        .d     ({hs_raw, vs_raw, active}),
        .q     (dly_q)
    );

    assign {hsync, vsync, de} = dly_q;

    assign x_coord     = x_q;
    assign y_coord     = y_q;
    assign frame_count = fc_q;
    assign line_start  = en && (x_q == '0);
    assign frame_start = en && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances share clock/reset/en.
//   a: default 640x480, active-low syncs, latency 1
//   b: 800x600 geometry, active-high syncs, latency 3, CW=11
//   c: tiny 15x8 raster, hsync high / vsync low, latency 0 (full frames, wrap)
// Expected outputs come from a closed-form model of k, the number of
// enabled clocks since the last reset or disable.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic pixel_clk = 1'b0;
    logic reset_n   = 1'b1;
    logic en        = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic [9:0]  a_x, a_y;
    logic [10:0] b_x, b_y;
    logic [3:0]  c_x, c_y;
    logic a_act, a_hs, a_vs, a_de, a_ls, a_fs;
    logic b_act, b_hs, b_vs, b_de, b_ls, b_fs;
    logic c_act, c_hs, c_vs, c_de, c_ls, c_fs;
    logic [7:0] a_fc, b_fc, c_fc;

    vga_timing_gen u_a (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .en(en),
        .x_coord(a_x), .y_coord(a_y), .active(a_act), .hsync(a_hs), .vsync(a_vs),
        .de(a_de), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HSYNC_POL(SYNC_ACTIVE_HIGH), .VSYNC_POL(SYNC_ACTIVE_HIGH),
        .PIX_LATENCY(3), .CW(11)
    ) u_b (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .en(en),
        .x_coord(b_x), .y_coord(b_y), .active(b_act), .hsync(b_hs), .vsync(b_vs),
        .de(b_de), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(SYNC_ACTIVE_HIGH), .VSYNC_POL(SYNC_ACTIVE_LOW),
        .PIX_LATENCY(0), .CW(4)
    ) u_c (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .en(en),
        .x_coord(c_x), .y_coord(c_y), .active(c_act), .hsync(c_hs), .vsync(c_vs),
        .de(c_de), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));

    int n_chk  = 0;
    int n_fail = 0;
    int k      = 0;
    logic chk_on = 1'b0;
    logic meas   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        int   x;
        int   y;
        int   fc;
        logic act, hs, vs, de, ls, fs;
    } exp_t;

    // Raster position is k mod line/frame length; delayed signals are the
    // raw decode of clock k-lat, idle before the pipe has filled.
    function automatic exp_t model(input int kk, input logic en_now,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input logic hp, input logic vp, input int lat);
        exp_t e;
        int ht, vt, j, hx, vy;
        ht    = ha + hf + hsw + hb;
        vt    = va + vf + vsw + vb;
        e.x   = kk % ht;
        e.y   = (kk / ht) % vt;
        e.fc  = (kk / (ht * vt)) % 256;
        e.act = (e.x < ha) && (e.y < va) && en_now;
        e.ls  = en_now && (e.x == 0);
        e.fs  = e.ls && (e.y == 0);
        e.hs  = !hp;
        e.vs  = !vp;
        e.de  = 1'b0;
        if (lat == 0) begin
            e.de = e.act;
            j    = kk;
        end else begin
            j = kk - lat;
        end
        if (j >= 0) begin
            hx = j % ht;
            vy = (j / ht) % vt;
            if (hx >= ha + hf && hx < ha + hf + hsw) e.hs = hp;
            if (vy >= va + vf && vy < va + vf + vsw) e.vs = vp;
            if (lat != 0) e.de = (hx < ha) && (vy < va);
        end
        return e;
    endfunction

    task automatic check_inst(input string p, input exp_t e,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic act, input logic hs, input logic vs, input logic de,
                              input logic ls, input logic fs, input logic [7:0] fc);
        chk({p, "_x"}, x, e.x);
        chk({p, "_y"}, y, e.y);
        chk({p, "_active"}, 32'(act), 32'(e.act));
        chk({p, "_hsync"}, 32'(hs), 32'(e.hs));
        chk({p, "_vsync"}, 32'(vs), 32'(e.vs));
        chk({p, "_de"}, 32'(de), 32'(e.de));
        chk({p, "_line_start"}, 32'(ls), 32'(e.ls));
        chk({p, "_frame_start"}, 32'(fs), 32'(e.fs));
        chk({p, "_frame_count"}, 32'(fc), e.fc);
    endtask

    task automatic check_all();
        int kk;
        kk = reset_n ? k : 0;
        check_inst("a", model(kk, en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1),
                   32'(a_x), 32'(a_y), a_act, a_hs, a_vs, a_de, a_ls, a_fs, a_fc);
        check_inst("b", model(kk, en, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 3),
                   32'(b_x), 32'(b_y), b_act, b_hs, b_vs, b_de, b_ls, b_fs, b_fc);
        check_inst("c", model(kk, en, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0, 0),
                   32'(c_x), 32'(c_y), c_act, c_hs, c_vs, c_de, c_ls, c_fs, c_fc);
    endtask

    // Enabled-clock counter behind the model.
    always @(posedge pixel_clk) begin
        if (!reset_n || !en) k = 0;
        else                 k = k + 1;
    end

    always @(negedge pixel_clk) begin
        if (chk_on) check_all();
    end

    // Pulse-shape measurements against the geometry numbers directly.
    int   a_run = 0, a_fall = -1, b_run = 0, b_rise = -1;
    int   c_vrun = 0, c_vfall = -1, c_fs_last = -1, c_de_cnt = 0;
    logic a_prev = 1'b1, b_prev = 1'b0, c_vprev = 1'b1;

    always @(negedge pixel_clk) begin
        if (meas) begin
            if (!a_hs) a_run++;
            else if (a_run != 0) begin chk("a_hs_width", a_run, 96); a_run = 0; end
            if (!a_hs && a_prev) begin
                if (a_fall < 0) chk("a_hs_first", k, 657);
                else            chk("a_hs_period", k - a_fall, 800);
                a_fall = k;
            end
            a_prev = a_hs;

            if (b_hs) b_run++;
            else if (b_run != 0) begin chk("b_hs_width", b_run, 128); b_run = 0; end
            if (b_hs && !b_prev) begin
                if (b_rise < 0) chk("b_hs_first", k, 843);
                else            chk("b_hs_period", k - b_rise, 1056);
                b_rise = k;
            end
            b_prev = b_hs;

            if (!c_vs) c_vrun++;
            else if (c_vrun != 0) begin chk("c_vs_width", c_vrun, 30); c_vrun = 0; end
            if (!c_vs && c_vprev && c_vfall < 0) begin chk("c_vs_first", k, 75); c_vfall = k; end
            c_vprev = c_vs;

            if (c_fs) begin
                if (c_fs_last >= 0) begin
                    chk("c_fs_period", k - c_fs_last, 120);
                    chk("c_de_per_frame", c_de_cnt, 32);
                end
                c_fs_last = k;
                c_de_cnt  = 0;
            end
            if (c_de) c_de_cnt++;

            if (k == 255 * 120) chk("c_fc_255", 32'(c_fc), 255);
            if (k == 256 * 120) begin
                chk("c_fc_wrap", 32'(c_fc), 0);
                chk("c_fs_wrap", 32'(c_fs), 1);
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1 en = 1'b1;
        @(posedge pixel_clk);
        #3 reset_n = 1'b1;
        meas = 1'b1;

        // Long uninterrupted run: > 256 frames of c, many lines of a and b.
        repeat (30800) @(posedge pixel_clk);
        #1 meas = 1'b0;

        // Drop en mid-line at x=300 for 5 clocks.
        for (int g = 0; g < 2000; g++) begin
            if ((k % 800) == 300) break;
            @(posedge pixel_clk);
            #1;
        end
        chk("a_x_at_drop", 32'(a_x), 300);
        en = 1'b0;
        @(posedge pixel_clk);
        #1;
        chk("a_drop_x", 32'(a_x), 0);
        chk("a_drop_y", 32'(a_y), 0);
        chk("a_drop_hs", 32'(a_hs), 1);
        chk("a_drop_vs", 32'(a_vs), 1);
        chk("a_drop_de", 32'(a_de), 0);
        chk("a_drop_fc", 32'(a_fc), 0);
        repeat (4) @(posedge pixel_clk);
        #1 en = 1'b1;
        #1;
        chk("a_rise_fs", 32'(a_fs), 1);
        chk("a_rise_fc", 32'(a_fc), 0);

        // Async reset in the middle of hsync (x=700).
        for (int g = 0; g < 2000; g++) begin
            if ((k % 800) == 700) break;
            @(posedge pixel_clk);
            #1;
        end
        chk("a_hs_at_700", 32'(a_hs), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("a_rst_hs", 32'(a_hs), 1);
        chk("a_rst_x", 32'(a_x), 0);
        chk("a_rst_y", 32'(a_y), 0);
        chk("a_rst_de", 32'(a_de), 0);
        chk("b_rst_hs", 32'(b_hs), 0);
        check_all();
        repeat (2) @(posedge pixel_clk);
        #3 reset_n = 1'b1;

        // Random mix of enable drops and asynchronous reset pulses.
        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(50, 1500)) @(posedge pixel_clk);
            #1;
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b0;
                repeat ($urandom_range(1, 8)) @(posedge pixel_clk);
                #1 en = 1'b1;
            end else begin
                #(($urandom_range(0, 1) == 1) ? 1 : 5);
                reset_n = 1'b0;
                #1 check_all();
                repeat ($urandom_range(1, 4)) @(posedge pixel_clk);
                #2 reset_n = 1'b1;
            end
        end
        repeat (200) @(posedge pixel_clk);
        #1 chk_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
